synapse_event_dispatcher: RTL and testbench

//  Parametrised successor of the single-event layer FSM.
//  - Buffers (left neuron, right neuron) synapse events from the connectivity memory in a FIFO.
//  - Dispatches them one at a time to the synapse register layer.
//  - Uses a 4-phase req/ack handshake per synapse, with a timeout and range checking.
//  - Sits between connectivity memory and the synapse register array.

---
 rtl/synapse_event_dispatcher_if.sv | 36 +++
 rtl/synapse_event_dispatcher.sv | 144 ++++++++++++++
 tb/tb_synapse_event_dispatcher.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/synapse_event_dispatcher_if.sv
// Event/synapse handshake bundle between connectivity memory, dispatcher and
// the synapse register array.
interface synapse_event_dispatcher_if #(
  parameter int N_LEFT     = 4,
  parameter int N_RIGHT    = 4,
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = (N_LEFT  > 1) ? $clog2(N_LEFT)  : 1;
  localparam int RW = (N_RIGHT > 1) ? $clog2(N_RIGHT) : 1;
  localparam int NS = N_LEFT * N_RIGHT;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          evt_valid;
  logic          evt_ready;
  logic [LW-1:0] evt_left;
  logic [RW-1:0] evt_right;
  logic [NS-1:0] syn_req;
  logic [NS-1:0] syn_ack;
  logic          done;
  logic          err_range;
  logic          err_timeout;
  logic          busy;
  logic [CW-1:0] fifo_level;

  // Environment side: memory producer plus synapse register responder.
  modport master (
    output evt_valid, evt_left, evt_right, syn_ack,
    input  evt_ready, syn_req, done, err_range, err_timeout, busy, fifo_level
  );

  // Dispatcher side.
  modport slave (
    input  evt_valid, evt_left, evt_right, syn_ack,
    output evt_ready, syn_req, done, err_range, err_timeout, busy, fifo_level
  );
endinterface

// File: rtl/synapse_event_dispatcher.sv
// Synapse event dispatcher: queues (left, right) events in a FIFO and issues
// them one at a time as a one-hot 4-phase req/ack handshake with timeout.
module synapse_event_dispatcher #(
  parameter int N_LEFT     = 4,
  parameter int N_RIGHT    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  synapse_event_dispatcher_if.slave bus
);
  localparam int LW = (N_LEFT  > 1) ? $clog2(N_LEFT)  : 1;
  localparam int RW = (N_RIGHT > 1) ? $clog2(N_RIGHT) : 1;
  localparam int NS = N_LEFT * N_RIGHT;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [LW:0]   L_LIM   = (LW + 1)'(N_LEFT);
  localparam logic [RW:0]   R_LIM   = (RW + 1)'(N_RIGHT);
  localparam logic [CW-1:0] LVL_MAX = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  logic [LW-1:0] r_left_mem  [FIFO_DEPTH];
  logic [RW-1:0] r_right_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_level;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [NS-1:0] r_syn_req, w_syn_req_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err_timeout, w_err_timeout_nxt;
  logic          r_err_range;

  logic w_ready, w_accept, w_in_range, w_push, w_pop, w_ack;

  assign w_ready    = (r_level != LVL_MAX);
  assign w_accept   = bus.evt_valid && w_ready;
  assign w_in_range = ({1'b0, bus.evt_left} < L_LIM) && ({1'b0, bus.evt_right} < R_LIM);
  assign w_push     = w_accept && w_in_range;
  assign w_ack      = bus.syn_ack[r_idx];

  // Event FIFO storage, pointers and occupancy; out-of-range events are never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_left_mem[r_wr_ptr]  <= bus.evt_left;
        r_right_mem[r_wr_ptr] <= bus.evt_right;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // Range error pulse for a consumed-but-discarded event.
  always_ff @(posedge clk) begin
    if (!rst_n) r_err_range <= 1'b0;
    else        r_err_range <= w_accept && !w_in_range;
  end

  // Handshake FSM state, timer, latched index and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_idx         <= '0;
      r_syn_req     <= '0;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_idx         <= w_idx_nxt;
      r_syn_req     <= w_syn_req_nxt;
      r_done        <= w_done_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end

  // Next-state, pop and output decode; syn_req follows the current state one cycle later.
  always_comb begin
    w_state_nxt       = r_state;
    w_timer_nxt       = r_timer;
    w_idx_nxt         = r_idx;
    w_syn_req_nxt     = '0;
    w_done_nxt        = 1'b0;
    w_err_timeout_nxt = 1'b0;
    w_pop             = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_idx_nxt   = IW'(r_left_mem[r_rd_ptr]) + IW'(N_LEFT) * IW'(r_right_mem[r_rd_ptr]);
          w_timer_nxt = '0;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_syn_req_nxt[r_idx] = 1'b1;
        if (w_ack) begin
          w_state_nxt = REL;
          w_timer_nxt = '0;
        end else if (r_timer == T_LAST) begin
          w_state_nxt       = IDLE;
          w_err_timeout_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      REL: begin
        if (!w_ack) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_timer == T_LAST) begin
          w_state_nxt       = IDLE;
          w_err_timeout_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.evt_ready   = w_ready;
  assign bus.syn_req     = r_syn_req;
  assign bus.done        = r_done;
  assign bus.err_range   = r_err_range;
  assign bus.err_timeout = r_err_timeout;
  assign bus.busy        = (r_state != IDLE) || (r_level != '0);
  assign bus.fifo_level  = r_level;
endmodule

// File: tb/tb_synapse_event_dispatcher.sv
// Scoreboard bench for synapse_event_dispatcher: stimulus queues the expected
// dispatch order/outcome, a monitor checks each request and completion pulse.
module tb_synapse_event_dispatcher;
  localparam int NL  = 4;
  localparam int NR  = 4;
  localparam int FD  = 8;
  localparam int TO  = 16;
  localparam int NS  = NL * NR;
  localparam int BNL = 5;
  localparam int BNR = 3;
  localparam int BNS = BNL * BNR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  synapse_event_dispatcher_if #(.N_LEFT(NL), .N_RIGHT(NR), .FIFO_DEPTH(FD)) if_a ();
  synapse_event_dispatcher_if #(.N_LEFT(BNL), .N_RIGHT(BNR), .FIFO_DEPTH(FD)) if_b ();

  synapse_event_dispatcher #(.N_LEFT(NL), .N_RIGHT(NR), .FIFO_DEPTH(FD), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(if_a));

  synapse_event_dispatcher #(.N_LEFT(BNL), .N_RIGHT(BNR), .FIFO_DEPTH(FD), .TIMEOUT(TO)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));

  typedef struct {
    int idx;
    bit tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ack_mode = 0;   // 0: echo after one cycle, 1: never ack, 2: ack after 8 cycles
  bit   full_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synapse register model for instance A.
  initial begin : resp_a
    logic [NS-1:0] d1;
    int cnt;
    d1 = '0;
    cnt = 0;
    if_a.syn_ack = '0;
    forever begin
      @(negedge clk);
      case (ack_mode)
        0: begin
          if_a.syn_ack = d1;
          d1 = if_a.syn_req;
        end
        1: if_a.syn_ack = '0;
        default: begin
          if (if_a.syn_req == '0) begin
            cnt = 0;
            if_a.syn_ack = '0;
          end else begin
            cnt++;
            if (cnt >= 8) if_a.syn_ack = if_a.syn_req;
          end
        end
      endcase
    end
  end

  // Instance B always echoes its request one cycle later.
  initial begin : resp_b
    logic [BNS-1:0] d1;
    d1 = '0;
    if_b.syn_ack = '0;
    forever begin
      @(negedge clk);
      if_b.syn_ack = d1;
      d1 = if_b.syn_req;
    end
  end

  // Scoreboard monitor for instance A.
  initial begin : monitor
    logic [NS-1:0] prev_req;
    logic [NS-1:0] want;
    bit   have_cur;
    exp_t cur;
    prev_req = '0;
    have_cur = 0;
    cur.idx  = 0;
    cur.tmo  = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        have_cur = 0;
        prev_req = '0;
      end else begin
        if (if_a.syn_req != '0 && prev_req == '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_dispatch", 32'(if_a.syn_req), 32'd0);
          end else begin
            cur  = exp_q.pop_front();
            want = '0;
            want[cur.idx] = 1'b1;
            check("dispatch_order", 32'(if_a.syn_req), 32'(want));
            have_cur = 1;
          end
        end
        if (if_a.done === 1'b1) begin
          check("done_expected", 32'(have_cur && !cur.tmo), 32'd1);
          have_cur = 0;
        end
        if (if_a.err_timeout === 1'b1) begin
          check("timeout_expected", 32'(have_cur && cur.tmo), 32'd1);
          have_cur = 0;
        end
        if (if_a.err_range === 1'b1) check("range_a", 32'(if_a.err_range), 32'd0);
        prev_req = if_a.syn_req;
      end
    end
  end

  task automatic push(input int l, input int r, input bit tmo);
    int   n;
    exp_t e;
    logic [31:0] lv, rv;
    lv = l;
    rv = r;
    if_a.evt_left  = lv[1:0];
    if_a.evt_right = rv[1:0];
    if_a.evt_valid = 1'b1;
    if (if_a.evt_ready !== 1'b1) begin
      full_seen = 1;
      check("full_level", 32'(if_a.fifo_level), FD);
    end
    n = 0;
    while (if_a.evt_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("push_ready", 32'(if_a.evt_ready), 32'd1);
    e.idx = l + NL * r;
    e.tmo = tmo;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (if_a.busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(if_a.busy), 32'd0);
    repeat (2) @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int cnt;
    logic [31:0] v;
    if_a.evt_valid = 1'b1;
    if_a.evt_left  = 2'd1;
    if_a.evt_right = 2'd1;
    if_b.evt_valid = 1'b0;
    if_b.evt_left  = '0;
    if_b.evt_right = '0;
    rst_n = 1'b0;

    // Reset held with a valid event present.
    repeat (3) begin
      @(negedge clk);
      check("rst_syn_req", 32'(if_a.syn_req), 32'd0);
      check("rst_level", 32'(if_a.fifo_level), 32'd0);
      check("rst_pulses", {29'd0, if_a.done, if_a.err_range, if_a.err_timeout}, 32'd0);
    end
    if_a.evt_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(if_a.evt_ready), 32'd1);
    check("post_rst_busy", 32'(if_a.busy), 32'd0);

    // Single event left=2 right=1 -> bit 6, visible two edges after acceptance.
    ack_mode = 0;
    push(2, 1, 0);
    if_a.evt_valid = 1'b0;
    check("lat_t0", 32'(if_a.syn_req), 32'd0);
    @(negedge clk);
    check("lat_t1", 32'(if_a.syn_req), 32'd0);
    @(negedge clk);
    check("lat_t2", 32'(if_a.syn_req), 32'h0040);
    wait_idle("single_idle");

    // Burst of 10 events with slow ack: fills the FIFO, order preserved.
    ack_mode = 2;
    full_seen = 0;
    for (int i = 0; i < 10; i++) push(i % 4, i / 4, 0);
    if_a.evt_valid = 1'b0;
    check("burst_hit_full", 32'(full_seen), 32'd1);
    wait_idle("burst_idle");

    // No ack: each request stays up exactly TIMEOUT cycles, then the next is issued.
    ack_mode = 1;
    push(0, 0, 1);
    push(3, 3, 1);
    if_a.evt_valid = 1'b0;
    n = 0;
    while (if_a.syn_req == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    while (if_a.syn_req != '0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_req_cycles", cnt, TO);
    wait_idle("timeout_idle");

    // Out-of-range events on the 5x3 instance.
    @(negedge clk);
    if_b.evt_left = 3'd5; if_b.evt_right = 2'd0; if_b.evt_valid = 1'b1;
    @(negedge clk);
    if_b.evt_valid = 1'b0;
    check("range_left_pulse", 32'(if_b.err_range), 32'd1);
    check("range_left_level", 32'(if_b.fifo_level), 32'd0);
    check("range_left_req", 32'(if_b.syn_req), 32'd0);
    @(negedge clk);
    check("range_left_clear", 32'(if_b.err_range), 32'd0);
    check("range_left_busy", 32'(if_b.busy), 32'd0);
    if_b.evt_left = 3'd0; if_b.evt_right = 2'd3; if_b.evt_valid = 1'b1;
    @(negedge clk);
    if_b.evt_valid = 1'b0;
    check("range_right_pulse", 32'(if_b.err_range), 32'd1);
    check("range_right_level", 32'(if_b.fifo_level), 32'd0);
    if_b.evt_left = 3'd4; if_b.evt_right = 2'd2; if_b.evt_valid = 1'b1;
    @(negedge clk);
    if_b.evt_valid = 1'b0;
    check("range_valid_noerr", 32'(if_b.err_range), 32'd0);
    n = 0;
    while (if_b.syn_req == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    v = 32'd1 << 14;
    check("range_valid_req", 32'(if_b.syn_req), v);

    // Reset while in REQ with three events still queued.
    ack_mode = 1;
    push(1, 0, 1);
    push(2, 0, 1);
    push(3, 0, 1);
    push(0, 1, 1);
    if_a.evt_valid = 1'b0;
    n = 0;
    while (if_a.fifo_level != 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst_level", 32'(if_a.fifo_level), 32'd3);
    check("midrst_req", 32'(if_a.syn_req), 32'h0002);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_syn_req", 32'(if_a.syn_req), 32'd0);
    check("midrst_fifo", 32'(if_a.fifo_level), 32'd0);
    check("midrst_done", 32'(if_a.done), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_busy", 32'(if_a.busy), 32'd0);
    check("midrst_no_req", 32'(if_a.syn_req), 32'd0);
    check("final_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
